// File: rtl/pa2se.sv
// pa2se - parallel-to-serial converter for the FFT32 datapath.
// Accepts a frame as WORDS consecutive LANES-wide complex words and emits it
// one complex sample per clock through a two-bank ping-pong buffer, so that
// one frame can fill while the previous one drains.
// Optional build macro PA2SE_BITREV_EN: drain in bit-reversed sample order.
// Without it the drain follows natural order and starts right after word 0.
module pa2se #(
    parameter int nb    = 16,
    parameter int LANES = 4,
    parameter int FRAME = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [nb*LANES-1:0] DR,
    input  logic [nb*LANES-1:0] DI,
    output logic [nb-1:0]       OR,
    output logic [nb-1:0]       OI,
    output logic                VLD,
    output logic                RDY,
    output logic                BUSY,
    output logic                ERR
);

    localparam int WORDS = FRAME / LANES;
    localparam int NW    = $clog2(FRAME);
    localparam int LW    = $clog2(LANES);
    localparam int WW    = NW - LW;
    localparam int W     = nb * LANES;

    typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL, B_DRAIN} bank_state_t;
    typedef enum logic {W_IDLE, W_FILL} wr_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

    // Frame storage, address = {bank, word}. Kept as registers rather than
    // block RAM because sample 0 must leave one cycle after word 0 lands.
    logic [W-1:0] mem_r_q [2*WORDS];
    logic [W-1:0] mem_i_q [2*WORDS];

    // Bank bookkeeping
    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic [1:0]  bank_free;
    logic [1:0]  bank_elig;

    // Write side
    wr_state_t       wr_state_q, wr_state_d;
    logic [WW-1:0]   wr_cnt_q, wr_cnt_d;
    logic            wr_bank_q, wr_bank_d;
    logic            last_alloc_q, last_alloc_d;
    logic            err_q, err_d;
    logic            wr_en;
    logic            wr_start;
    logic            wr_end;
    logic [WW-1:0]   wr_word;

    // Read side
    rd_state_t       rd_state_q, rd_state_d;
    logic [NW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            rd_bank_q, rd_bank_d;
    logic            rd_pick;
    logic            rd_sel;
    logic            rd_en;
    logic            rd_first;
    logic            rd_last;
    logic            drain_start;
    logic [NW-1:0]   rd_idx;
    logic [NW-1:0]   mem_idx;
    logic [WW:0]     rd_addr;
    logic [W-1:0]    rd_word_r;
    logic [W-1:0]    rd_word_i;
    logic [nb-1:0]   lane_r [LANES];
    logic [nb-1:0]   lane_i [LANES];

    // Output registers
    logic [nb-1:0]   or_q, oi_q;
    logic            vld_q, rdy_q;
    logic            last_q;
    logic            out_bank_q;

    // Per-bank status decode; drain eligibility depends on the output order
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign bank_free[gi] = (bank_q[gi] == B_FREE);
`ifdef PA2SE_BITREV_EN
        assign bank_elig[gi] = (bank_q[gi] == B_FULL);
`else
        assign bank_elig[gi] = (bank_q[gi] == B_FILL) || (bank_q[gi] == B_FULL);
`endif
    end

    assign BUSY = (wr_state_q == W_FILL) || (bank_free == 2'b00);
    assign ERR  = err_q;

    // Write FSM: allocate the lower free bank on START, then count words
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_cnt_d     = wr_cnt_q;
        wr_bank_d    = wr_bank_q;
        last_alloc_d = last_alloc_q;
        err_d        = err_q;
        wr_en        = 1'b0;
        wr_start     = 1'b0;
        wr_end       = 1'b0;
        wr_word      = wr_cnt_q;
        case (wr_state_q)
            W_IDLE: begin
                if (START) begin
                    if (bank_free != 2'b00) begin
                        wr_bank_d    = bank_free[0] ? 1'b0 : 1'b1;
                        last_alloc_d = wr_bank_d;
                        wr_en        = 1'b1;
                        wr_start     = 1'b1;
                        wr_word      = '0;
                        wr_cnt_d     = WW'(1);
                        wr_state_d   = W_FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            W_FILL: begin
                // A START mid-fill cannot be honoured; flag it and carry on
                if (START) begin
                    err_d = 1'b1;
                end
                wr_en    = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == WW'(WORDS - 1)) begin
                    wr_end     = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
        endcase
    end

    // Read FSM: the oldest eligible bank wins; the first read happens in IDLE
    always_comb begin
        rd_pick     = (bank_elig == 2'b11) ? ~last_alloc_q : (bank_elig[0] ? 1'b0 : 1'b1);
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        rd_sel      = rd_bank_q;
        rd_idx      = rd_cnt_q;
        rd_en       = 1'b0;
        rd_first    = 1'b0;
        rd_last     = 1'b0;
        drain_start = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (bank_elig != 2'b00) begin
                    rd_sel      = rd_pick;
                    rd_bank_d   = rd_pick;
                    rd_idx      = '0;
                    rd_en       = 1'b1;
                    rd_first    = 1'b1;
                    drain_start = 1'b1;
                    rd_cnt_d    = NW'(1);
                    rd_state_d  = R_DRAIN;
                end
            end
            R_DRAIN: begin
                rd_en    = 1'b1;
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == NW'(FRAME - 1)) begin
                    rd_last    = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
        endcase
    end

    // Map serial sample number to stored index
`ifdef PA2SE_BITREV_EN
    for (genvar gi = 0; gi < NW; gi++) begin : g_rev
        assign mem_idx[gi] = rd_idx[NW-1-gi];
    end
`else
    assign mem_idx = rd_idx;
`endif

    assign rd_addr   = {rd_sel, mem_idx[NW-1:LW]};
    assign rd_word_r = mem_r_q[rd_addr];
    assign rd_word_i = mem_i_q[rd_addr];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_r[gi] = rd_word_r[nb*gi +: nb];
        assign lane_i[gi] = rd_word_i[nb*gi +: nb];
    end

    // Bank lifecycle: free after last sample leaves, drain, fill, full
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (last_q && (out_bank_q == 1'(b))) begin
                bank_d[b] = B_FREE;
            end else if (drain_start && (rd_sel == 1'(b))) begin
                bank_d[b] = B_DRAIN;
            end else if (wr_start && (wr_bank_d == 1'(b))) begin
                bank_d[b] = B_FILL;
            end else if (wr_end && (wr_bank_q == 1'(b)) && (bank_q[b] == B_FILL)) begin
                // A bank already draining stays DRAIN when its fill completes
                bank_d[b] = B_FULL;
            end
        end
    end

    // Frame storage write port (no reset: contents are don't-care when FREE)
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_r_q[{wr_bank_d, wr_word}] <= DR;
            mem_i_q[{wr_bank_d, wr_word}] <= DI;
        end
    end

    // Control state registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_state_q   <= W_IDLE;
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            last_alloc_q <= 1'b0;
            err_q        <= 1'b0;
            rd_state_q   <= R_IDLE;
            rd_cnt_q     <= '0;
            rd_bank_q    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= B_FREE;
            end
        end else begin
            wr_state_q   <= wr_state_d;
            wr_cnt_q     <= wr_cnt_d;
            wr_bank_q    <= wr_bank_d;
            last_alloc_q <= last_alloc_d;
            err_q        <= err_d;
            rd_state_q   <= rd_state_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_bank_q    <= rd_bank_d;
            bank_q       <= bank_d;
        end
    end

    // Serial output stage; data forced to zero outside valid cycles
    always_ff @(posedge CLK) begin
        if (!RST) begin
            or_q       <= '0;
            oi_q       <= '0;
            vld_q      <= 1'b0;
            rdy_q      <= 1'b0;
            last_q     <= 1'b0;
            out_bank_q <= 1'b0;
        end else begin
            or_q       <= rd_en ? lane_r[mem_idx[LW-1:0]] : '0;
            oi_q       <= rd_en ? lane_i[mem_idx[LW-1:0]] : '0;
            vld_q      <= rd_en;
            rdy_q      <= rd_first;
            last_q     <= rd_last;
            out_bank_q <= rd_sel;
        end
    end

    assign OR  = or_q;
    assign OI  = oi_q;
    assign VLD = vld_q;
    assign RDY = rdy_q;

endmodule

// File: tb/tb_pa2se.sv
// tb_pa2se - directed bench for pa2se with an expected-sample scoreboard.
module tb_pa2se;

    localparam int NB    = 16;
    localparam int LANES = 4;
    localparam int FRAME = 32;
    localparam int WORDS = FRAME / LANES;
`ifdef PA2SE_BITREV_EN
    localparam int LAT    = WORDS + 1;
    localparam bit BITREV = 1'b1;
`else
    localparam int LAT    = 2;
    localparam bit BITREV = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                RST;
    logic                START;
    logic [NB*LANES-1:0] DR;
    logic [NB*LANES-1:0] DI;
    logic [NB-1:0]       OR;
    logic [NB-1:0]       OI;
    logic                VLD;
    logic                RDY;
    logic                BUSY;
    logic                ERR;

    pa2se #(.nb(NB), .LANES(LANES), .FRAME(FRAME)) dut (
        .CLK(CLK), .RST(RST), .START(START), .DR(DR), .DI(DI),
        .OR(OR), .OI(OI), .VLD(VLD), .RDY(RDY), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int r;
        int i;
        bit rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   next_free = 0;
    bit   mon_en    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic int rev_idx(input int n);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (n[b]) r |= (1 << (4 - b));
        end
        return r;
    endfunction

    // Expected serial samples of a frame whose START is at cycle t
    task automatic push_frame(input int t, input int base);
        int   s;
        exp_t e;
        s = (t + LAT > next_free) ? t + LAT : next_free;
        for (int n = 0; n < FRAME; n++) begin
            int idx;
            idx   = BITREV ? rev_idx(n) : n;
            e.cyc = s + n;
            e.r   = base + idx;
            e.i   = base + 100 + idx;
            e.rdy = (n == 0);
            exp_q.push_back(e);
        end
        next_free = s + FRAME;
    endtask

    // Drive WORDS words from the current cycle; dup_k re-pulses START mid-fill
    task automatic send_frame(input int base, input int dup_k);
        for (int k = 0; k < WORDS; k++) begin
            START = (k == 0) || (k == dup_k);
            for (int l = 0; l < LANES; l++) begin
                DR[NB*l +: NB] = NB'(base + 4*k + l);
                DI[NB*l +: NB] = NB'(base + 100 + 4*k + l);
            end
            step(1);
            if (k == 0) chk("busy_while_filling", BUSY, 1);
        end
        START = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step(1);
        step(2);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        step(1);
        RST = 1'b1;
        exp_q.delete();
        next_free = 0;
    endtask

    // Output monitor: one comparison set per valid sample
    always @(negedge CLK) begin
        if (mon_en) begin
            if (VLD === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("vld_unexpected@%0d", cyc), VLD, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("OR@%0d", cyc), OR, e.r);
                    chk($sformatf("OI@%0d", cyc), OI, e.i);
                    chk($sformatf("RDY@%0d", cyc), RDY, e.rdy);
                    chk($sformatf("sample_cycle@%0d", cyc), cyc, e.cyc);
                    $display("sample cyc=%0d OR=%0d OI=%0d RDY=%0d", cyc, OR, OI, RDY);
                end
            end else begin
                chk($sformatf("VLD_idle@%0d", cyc), VLD, 0);
                chk($sformatf("RDY_idle@%0d", cyc), RDY, 0);
                if (exp_q.size() > 0)
                    chk($sformatf("sample_overdue@%0d", cyc), 32'(exp_q[0].cyc <= cyc), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        RST = 1'b0; START = 1'b0; DR = '0; DI = '0;
        step(2);
        chk("reset_OR", OR, 0);
        chk("reset_OI", OI, 0);
        chk("reset_VLD", VLD, 0);
        chk("reset_RDY", RDY, 0);
        chk("reset_BUSY", BUSY, 0);
        chk("reset_ERR", ERR, 0);
        RST = 1'b1;
        step(1);
        mon_en = 1'b1;

        // Single frame
        t = cyc;
        chk("single_busy_before", BUSY, 0);
        push_frame(t, 0);
        send_frame(0, -1);
        chk("single_busy_after_fill", BUSY, 0);
        wait_drain();
        chk("single_err", ERR, 0);

        // Three frames every FRAME cycles: gapless output, bank reuse
        t = cyc;
        push_frame(t, 1000);
        send_frame(1000, -1);
        step(FRAME - WORDS);
        chk("b2b_busy_f2", BUSY, 0);
        push_frame(cyc, 2000);
        send_frame(2000, -1);
        step(FRAME - WORDS);
        chk("b2b_busy_f3", BUSY, 0);
        push_frame(cyc, 3000);
        send_frame(3000, -1);
        wait_drain();
        chk("b2b_err", ERR, 0);

        // Overflow: third START with both banks occupied is dropped
        t = cyc;
        push_frame(t, 4000);
        send_frame(4000, -1);
        push_frame(cyc, 5000);
        send_frame(5000, -1);
        chk("ovf_busy", BUSY, 1);
        chk("ovf_err_before", ERR, 0);
        START = 1'b1;
        DR = {4{16'd9999}};
        DI = {4{16'd9999}};
        step(1);
        START = 1'b0;
        chk("ovf_err_after", ERR, 1);
        wait_drain();
        chk("ovf_err_sticky", ERR, 1);

        // START during fill is ignored, frame intact
        do_reset();
        chk("reset_clears_err", ERR, 0);
        t = cyc;
        push_frame(t, 6000);
        send_frame(6000, 3);
        chk("dup_start_err", ERR, 1);
        wait_drain();

        // Reset mid-drain discards the frame; a fresh frame follows
        t = cyc;
        push_frame(t, 7000);
        send_frame(7000, -1);
        step(2);
        RST = 1'b0;
        step(1);
        RST = 1'b1;
        exp_q.delete();
        next_free = 0;
        chk("rst_mid_VLD", VLD, 0);
        chk("rst_mid_OR", OR, 0);
        chk("rst_mid_OI", OI, 0);
        chk("rst_mid_BUSY", BUSY, 0);
        chk("rst_mid_ERR", ERR, 0);
        step(1);
        push_frame(cyc, 8000);
        send_frame(8000, -1);
        wait_drain();
        chk("final_err", ERR, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
